// File: rtl/bus_txn_tracker.sv
// Passive valid/ready transaction tracker. Each channel queues its accepted
// addresses, pairs each data beat with the oldest queued address, and parks
// the finished record in a per-channel slot. A round-robin arbiter drains the
// slots onto a single record stream. Errors are sticky until err_clr.
module bus_txn_tracker #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 8,
  parameter int LAT_WIDTH  = 16,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_WIDTH  = 32,
  parameter int CH_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_addr_valid,
  input  logic [NUM_CH-1:0]            ch_addr_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH-1:0]            ch_data_valid,
  input  logic [NUM_CH-1:0]            ch_data_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [CH_W-1:0]              rec_ch,
  output logic [ID_WIDTH-1:0]          rec_id,
  output logic [ADDR_WIDTH-1:0]        rec_addr,
  output logic [DATA_WIDTH-1:0]        rec_data,
  output logic [LAT_WIDTH-1:0]         rec_latency,
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            err_orphan,
  output logic [NUM_CH-1:0]            err_overflow,
  output logic [NUM_CH-1:0]            err_drop,
  output logic [NUM_CH-1:0]            err_timeout,
  output logic [NUM_CH-1:0]            err_stability,
  output logic [NUM_CH*CNT_WIDTH-1:0]  txn_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [LAT_WIDTH-1:0]  r_ts;
  logic [CH_W-1:0]       r_rr_ptr;
  logic                  r_hold;
  logic [CH_W-1:0]       r_hold_ch;
  logic [CH_W-1:0]       w_pick;
  logic                  w_pick_found;
  logic [CH_W-1:0]       w_grant;
  logic                  w_consume;
  logic [NUM_CH-1:0]     w_slot_valid;
  logic [NUM_CH-1:0]     w_take;
  logic [ID_WIDTH-1:0]   w_slot_id   [NUM_CH];
  logic [ADDR_WIDTH-1:0] w_slot_addr [NUM_CH];
  logic [DATA_WIDTH-1:0] w_slot_data [NUM_CH];
  logic [LAT_WIDTH-1:0]  w_slot_lat  [NUM_CH];

  // Channel index 'k' places after 'base', wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Free-running timestamp shared by all channels; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + LAT_WIDTH'(1);
  end

  // Round-robin search over full slots, nearest to the pointer wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_slot_valid[rr_index(r_rr_ptr, k)]) begin
        w_pick_found = 1'b1;
        w_pick       = rr_index(r_rr_ptr, k);
      end
    end
  end

  // A stalled grant is frozen so a newly filled slot cannot steal the bus.
  assign w_grant     = r_hold ? r_hold_ch : w_pick;
  assign rec_valid   = r_hold | w_pick_found;
  assign w_consume   = rec_valid & rec_ready;
  assign rec_ch      = rec_valid ? w_grant : '0;
  assign rec_id      = rec_valid ? w_slot_id[w_grant] : '0;
  assign rec_addr    = rec_valid ? w_slot_addr[w_grant] : '0;
  assign rec_data    = rec_valid ? w_slot_data[w_grant] : '0;
  assign rec_latency = rec_valid ? w_slot_lat[w_grant] : '0;

  // Arbiter state: hold the grant across stalls, advance pointer on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_hold    <= 1'b0;
      r_hold_ch <= '0;
    end else begin
      r_hold    <= rec_valid & ~rec_ready;
      r_hold_ch <= w_grant;
      if (w_consume)
        r_rr_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
      logic [ID_WIDTH-1:0]   r_mem_id   [DEPTH];
      logic [LAT_WIDTH-1:0]  r_mem_ts   [DEPTH];
      logic [PTR_W-1:0]      r_wr_ptr;
      logic [PTR_W-1:0]      r_rd_ptr;
      logic [PTR_W:0]        r_count;
      logic [ID_WIDTH-1:0]   r_id;
      logic                  r_slot_valid;
      logic [ID_WIDTH-1:0]   r_slot_id;
      logic [ADDR_WIDTH-1:0] r_slot_addr;
      logic [DATA_WIDTH-1:0] r_slot_data;
      logic [LAT_WIDTH-1:0]  r_slot_lat;
      logic [CNT_WIDTH-1:0]  r_txn_count;
      logic [4:0]            r_err;  // {stability, timeout, drop, overflow, orphan}
      logic                  r_addr_stall;
      logic                  r_data_stall;
      logic [ADDR_WIDTH-1:0] r_addr_prev;
      logic [DATA_WIDTH-1:0] r_data_prev;

      logic [ADDR_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_addr_hs, w_data_hs, w_empty, w_full;
      logic                  w_pop, w_push, w_capture;
      logic [LAT_WIDTH-1:0]  w_head_age;
      logic [4:0]            w_err_set;

      assign w_addr     = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_data     = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_addr_hs  = ch_addr_valid[gi] & ch_addr_ready[gi];
      assign w_data_hs  = ch_data_valid[gi] & ch_data_ready[gi];
      assign w_empty    = (r_count == '0);
      assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
      // Data only matches entries queued before this cycle.
      assign w_pop      = w_data_hs & ~w_empty;
      // A full queue still accepts when its head leaves this same cycle.
      assign w_push     = w_addr_hs & (~w_full | w_pop);
      assign w_head_age = r_ts - r_mem_ts[r_rd_ptr];
      assign w_capture  = w_pop & (~r_slot_valid | w_take[gi]);

      assign w_err_set[0] = w_data_hs & w_empty;
      assign w_err_set[1] = w_addr_hs & ~w_push;
      assign w_err_set[2] = w_pop & ~w_capture;
      assign w_err_set[3] = ~w_empty & (w_head_age == LAT_WIDTH'(TIMEOUT));
      assign w_err_set[4] = (r_addr_stall & (~ch_addr_valid[gi] | (w_addr != r_addr_prev))) |
                            (r_data_stall & (~ch_data_valid[gi] | (w_data != r_data_prev)));

      assign w_take[gi]       = w_consume & (w_grant == CH_W'(gi));
      assign w_slot_valid[gi] = r_slot_valid;
      assign w_slot_id[gi]    = r_slot_id;
      assign w_slot_addr[gi]  = r_slot_addr;
      assign w_slot_data[gi]  = r_slot_data;
      assign w_slot_lat[gi]   = r_slot_lat;

      assign err_orphan[gi]    = r_err[0];
      assign err_overflow[gi]  = r_err[1];
      assign err_drop[gi]      = r_err[2];
      assign err_timeout[gi]   = r_err[3];
      assign err_stability[gi] = r_err[4];
      assign txn_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_txn_count;

      // Outstanding-address storage; only entries between the pointers are live.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem_addr[r_wr_ptr] <= w_addr;
          r_mem_id[r_wr_ptr]   <= r_id;
          r_mem_ts[r_wr_ptr]   <= r_ts;
        end
      end

      // Queue pointers, IDs, completion slot, counters, flags and stall history.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wr_ptr     <= '0;
          r_rd_ptr     <= '0;
          r_count      <= '0;
          r_id         <= '0;
          r_slot_valid <= 1'b0;
          r_slot_id    <= '0;
          r_slot_addr  <= '0;
          r_slot_data  <= '0;
          r_slot_lat   <= '0;
          r_txn_count  <= '0;
          r_err        <= '0;
          r_addr_stall <= 1'b0;
          r_data_stall <= 1'b0;
          r_addr_prev  <= '0;
          r_data_prev  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_id     <= r_id + ID_WIDTH'(1);
          end
          if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          if (w_push && !w_pop)
            r_count <= r_count + (PTR_W+1)'(1);
          else if (!w_push && w_pop)
            r_count <= r_count - (PTR_W+1)'(1);

          if (w_capture) begin
            r_slot_valid <= 1'b1;
            r_slot_id    <= r_mem_id[r_rd_ptr];
            r_slot_addr  <= r_mem_addr[r_rd_ptr];
            r_slot_data  <= w_data;
            r_slot_lat   <= w_head_age;
            r_txn_count  <= r_txn_count + CNT_WIDTH'(1);
          end else if (w_take[gi]) begin
            r_slot_valid <= 1'b0;
          end

          r_err        <= (err_clr ? 5'b0 : r_err) | w_err_set;
          r_addr_stall <= ch_addr_valid[gi] & ~ch_addr_ready[gi];
          r_data_stall <= ch_data_valid[gi] & ~ch_data_ready[gi];
          r_addr_prev  <= w_addr;
          r_data_prev  <= w_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_bus_txn_tracker.sv
// Directed bench for bus_txn_tracker with a queue-based reference model that
// is compared against every output on each falling clock edge.
module tb_bus_txn_tracker;

  localparam int NCH = 3;
  localparam int TO  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    av = '0, ar = '0, dv = '0, dr = '0;
  logic [NCH*32-1:0] addr_bus = '0;
  logic [NCH*32-1:0] data_bus = '0;
  logic              rec_ready = 1'b0;
  logic              err_clr = 1'b0;
  logic              rec_valid;
  logic [1:0]        rec_ch;
  logic [7:0]        rec_id;
  logic [31:0]       rec_addr, rec_data;
  logic [15:0]       rec_latency;
  logic [NCH-1:0]    err_orphan, err_overflow, err_drop, err_timeout, err_stability;
  logic [NCH*32-1:0] txn_count;

  bus_txn_tracker #(.NUM_CH(NCH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4),
                    .ID_WIDTH(8), .LAT_WIDTH(16), .TIMEOUT(TO), .CNT_WIDTH(32), .CH_W(2)) dut (
    .clk(clk), .rst(rst),
    .ch_addr_valid(av), .ch_addr_ready(ar), .ch_addr(addr_bus),
    .ch_data_valid(dv), .ch_data_ready(dr), .ch_data(data_bus),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ch(rec_ch), .rec_id(rec_id),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_latency(rec_latency),
    .err_clr(err_clr), .err_orphan(err_orphan), .err_overflow(err_overflow),
    .err_drop(err_drop), .err_timeout(err_timeout), .err_stability(err_stability),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  id;
    logic [15:0] ts;
  } ent_t;

  ent_t           mq [NCH][$];
  logic [15:0]    m_ts;
  logic [7:0]     m_id   [NCH];
  bit             m_full [NCH];
  logic [7:0]     m_sid  [NCH];
  logic [31:0]    m_saddr[NCH];
  logic [31:0]    m_sdata[NCH];
  logic [15:0]    m_slat [NCH];
  logic [31:0]    m_cnt  [NCH];
  logic [NCH-1:0] m_orph, m_ovf, m_drop, m_to, m_stab;
  bit             m_pas  [NCH];
  bit             m_pds  [NCH];
  logic [31:0]    m_pa   [NCH];
  logic [31:0]    m_pd   [NCH];
  int             m_ptr;
  bit             m_hold;
  int             m_hold_ch;

  function automatic void m_pick(output bit v, output int g);
    v = 1'b0;
    g = 0;
    if (m_hold) begin
      v = 1'b1;
      g = m_hold_ch;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!v && m_full[(m_ptr + k) % NCH]) begin
          v = 1'b1;
          g = (m_ptr + k) % NCH;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_ts = '0; m_ptr = 0; m_hold = 1'b0; m_hold_ch = 0;
    m_orph = '0; m_ovf = '0; m_drop = '0; m_to = '0; m_stab = '0;
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_id[i] = '0; m_full[i] = 1'b0; m_sid[i] = '0; m_saddr[i] = '0;
      m_sdata[i] = '0; m_slat[i] = '0; m_cnt[i] = '0;
      m_pas[i] = 1'b0; m_pds[i] = 1'b0; m_pa[i] = '0; m_pd[i] = '0;
    end
  endtask

  task automatic model_step();
    bit gv, consume, take, popped, captured, s_orph, s_ovf, s_drop, s_to, s_stab;
    int g, sz;
    logic [31:0] a, d;
    ent_t h;
    m_pick(gv, g);
    consume = gv && rec_ready;
    for (int i = 0; i < NCH; i++) begin
      a = addr_bus[i*32 +: 32];
      d = data_bus[i*32 +: 32];
      sz = mq[i].size();
      take = consume && (g == i);
      popped = 1'b0; captured = 1'b0;
      s_orph = 1'b0; s_ovf = 1'b0; s_drop = 1'b0;
      s_stab = (m_pas[i] && (!av[i] || a != m_pa[i])) || (m_pds[i] && (!dv[i] || d != m_pd[i]));
      s_to = (sz > 0) && (16'(m_ts - mq[i][0].ts) == 16'(TO));
      if (dv[i] && dr[i]) begin
        if (sz == 0) s_orph = 1'b1;
        else begin
          h = mq[i].pop_front();
          popped = 1'b1;
          if (!m_full[i] || take) begin
            captured = 1'b1;
            m_full[i] = 1'b1; m_sid[i] = h.id; m_saddr[i] = h.addr;
            m_sdata[i] = d; m_slat[i] = m_ts - h.ts; m_cnt[i] = m_cnt[i] + 1;
          end else s_drop = 1'b1;
        end
      end
      if (take && !captured) m_full[i] = 1'b0;
      if (av[i] && ar[i]) begin
        if (sz < 4 || popped) begin
          mq[i].push_back('{addr: a, id: m_id[i], ts: m_ts});
          m_id[i] = m_id[i] + 8'd1;
        end else s_ovf = 1'b1;
      end
      m_orph[i] = (err_clr ? 1'b0 : m_orph[i]) | s_orph;
      m_ovf[i]  = (err_clr ? 1'b0 : m_ovf[i])  | s_ovf;
      m_drop[i] = (err_clr ? 1'b0 : m_drop[i]) | s_drop;
      m_to[i]   = (err_clr ? 1'b0 : m_to[i])   | s_to;
      m_stab[i] = (err_clr ? 1'b0 : m_stab[i]) | s_stab;
      m_pas[i] = av[i] && !ar[i]; m_pa[i] = a;
      m_pds[i] = dv[i] && !dr[i]; m_pd[i] = d;
    end
    if (consume) m_ptr = (g + 1) % NCH;
    m_hold = gv && !rec_ready;
    m_hold_ch = g;
    m_ts = m_ts + 16'd1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle comparison ----------------
  bit c_v;
  int c_g;
  always @(negedge clk) begin
    if (run_cmp) begin
      m_pick(c_v, c_g);
      chk("rec_valid", rec_valid, c_v);
      if (c_v) begin
        chk("rec_ch", rec_ch, c_g);
        chk("rec_id", rec_id, m_sid[c_g]);
        chk("rec_addr", rec_addr, m_saddr[c_g]);
        chk("rec_data", rec_data, m_sdata[c_g]);
        chk("rec_latency", rec_latency, m_slat[c_g]);
        if (rec_ready)
          $display("record ch=%0d id=%0d addr=0x%0h data=0x%0h lat=%0d",
                   rec_ch, rec_id, rec_addr, rec_data, rec_latency);
      end
      chk("err_orphan", err_orphan, m_orph);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_drop", err_drop, m_drop);
      chk("err_timeout", err_timeout, m_to);
      chk("err_stability", err_stability, m_stab);
      for (int i = 0; i < NCH; i++)
        chk($sformatf("txn_count%0d", i), txn_count[i*32 +: 32], m_cnt[i]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input int ch, input logic [31:0] v);
    addr_bus[ch*32 +: 32] = v;
  endtask

  task automatic set_d(input int ch, input logic [31:0] v);
    data_bus[ch*32 +: 32] = v;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    run_cmp = 1'b1;
    step();
    chk("reset_rec_valid", rec_valid, 0);
    chk("reset_err_orphan", err_orphan, 0);
    chk("reset_txn_count", txn_count, 0);

    // Single ch0 transaction, data three cycles after the address.
    rec_ready = 1'b1;
    av[0] = 1; ar[0] = 1; set_a(0, 32'h100); step(); av[0] = 0; ar[0] = 0;
    step(); step();
    dv[0] = 1; dr[0] = 1; set_d(0, 32'hDEADBEEF); step(); dv[0] = 0; dr[0] = 0;
    chk("t1_valid", rec_valid, 1);
    chk("t1_ch", rec_ch, 0);
    chk("t1_id", rec_id, 0);
    chk("t1_addr", rec_addr, 32'h100);
    chk("t1_data", rec_data, 32'hDEADBEEF);
    chk("t1_latency", rec_latency, 3);
    chk("t1_count0", txn_count[31:0], 1);
    step();
    chk("t1_consumed", rec_valid, 0);

    // ch1: fill the queue, overflow once, then drain in order.
    av[1] = 1; ar[1] = 1;
    for (int k = 0; k < 4; k++) begin
      set_a(1, 32'(4 * k)); step();
    end
    set_a(1, 32'h10); step();
    av[1] = 0; ar[1] = 0;
    chk("t2_overflow", err_overflow, 3'b010);
    dv[1] = 1; dr[1] = 1;
    for (int k = 0; k < 4; k++) begin
      set_d(1, 32'h1000 + 32'(k)); step();
      chk($sformatf("t2_id%0d", k), rec_id, k);
      chk($sformatf("t2_addr%0d", k), rec_addr, 4 * k);
      chk($sformatf("t2_lat%0d", k), rec_latency, 5);
    end
    dv[1] = 0; dr[1] = 0;
    step();
    av[1] = 1; ar[1] = 1; set_a(1, 32'h20); step(); av[1] = 0; ar[1] = 0;
    dv[1] = 1; dr[1] = 1; set_d(1, 32'h2020); step(); dv[1] = 0; dr[1] = 0;
    chk("t2_id_after_ovf", rec_id, 4);
    chk("t2_addr_after_ovf", rec_addr, 32'h20);
    chk("t2_lat_after_ovf", rec_latency, 1);
    step();

    // ch2 orphan data, then clear.
    dv[2] = 1; dr[2] = 1; set_d(2, 32'h77); step(); dv[2] = 0; dr[2] = 0;
    chk("t3_orphan", err_orphan, 3'b100);
    chk("t3_no_record", rec_valid, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("t3_orphan_clr", err_orphan, 0);
    chk("t3_overflow_clr", err_overflow, 0);

    // Simultaneous ch0/ch1 completions under back-pressure.
    rec_ready = 0;
    av[0] = 1; ar[0] = 1; av[1] = 1; ar[1] = 1;
    set_a(0, 32'h200); set_a(1, 32'h300); step();
    av = '0; ar = '0;
    dv[0] = 1; dr[0] = 1; dv[1] = 1; dr[1] = 1;
    set_d(0, 32'hA0); set_d(1, 32'hA1); step();
    dv = '0; dr = '0;
    chk("t4_grant0_a", rec_ch, 0);
    step(); chk("t4_grant0_b", rec_ch, 0);
    step(); chk("t4_grant0_c", rec_ch, 0);
    rec_ready = 1; step();
    chk("t4_then_ch1", rec_ch, 1);
    chk("t4_then_ch1_data", rec_data, 32'hA1);
    step(); chk("t4_drained", rec_valid, 0);

    // Drop: ch1 holds the stalled grant while ch0 completes twice.
    rec_ready = 0;
    av[0] = 1; ar[0] = 1; av[1] = 1; ar[1] = 1;
    set_a(0, 32'h500); set_a(1, 32'h400); step();
    av[1] = 0; ar[1] = 0; set_a(0, 32'h504); step();
    av = '0; ar = '0;
    dv[1] = 1; dr[1] = 1; set_d(1, 32'hB1); step(); dv[1] = 0; dr[1] = 0;
    dv[0] = 1; dr[0] = 1; set_d(0, 32'hB0); step();
    chk("t4_hold_ch1", rec_ch, 1);
    set_d(0, 32'hB4); step(); dv[0] = 0; dr[0] = 0;
    chk("t4_drop", err_drop, 3'b001);
    chk("t4_count0", txn_count[31:0], 3);
    chk("t4_count1", txn_count[63:32], 7);
    rec_ready = 1; step();
    chk("t4_ch0_after", rec_ch, 0);
    chk("t4_ch0_addr", rec_addr, 32'h500);
    chk("t4_ch0_data", rec_data, 32'hB0);
    chk("t4_ch0_lat", rec_latency, 3);
    step();
    err_clr = 1; step(); err_clr = 0;

    // Timeout on ch2.
    av[2] = 1; ar[2] = 1; set_a(2, 32'h600); step(); av[2] = 0; ar[2] = 0;
    repeat (TO - 1) step();
    chk("t5_not_yet", err_timeout, 0);
    step();
    chk("t5_timeout", err_timeout, 3'b100);
    dv[2] = 1; dr[2] = 1; set_d(2, 32'h66); step(); dv[2] = 0; dr[2] = 0;
    chk("t5_lat", rec_latency, TO + 1);
    step();
    err_clr = 1; step(); err_clr = 0;

    // Stability violation, then asynchronous reset mid-queue.
    av[0] = 1; ar[0] = 0; set_a(0, 32'h10); step();
    set_a(0, 32'h14); step();
    chk("t6_stability", err_stability, 3'b001);
    ar[0] = 1; step(); av[0] = 0; ar[0] = 0;
    #1 rst = 1;
    #1;
    chk("t6_rst_valid", rec_valid, 0);
    chk("t6_rst_stab", err_stability, 0);
    chk("t6_rst_count", txn_count, 0);
    step();
    rst = 0;
    step();
    dv[0] = 1; dr[0] = 1; set_d(0, 32'h99); step(); dv[0] = 0; dr[0] = 0;
    chk("t6_orphan", err_orphan, 3'b001);
    chk("t6_no_record", rec_valid, 0);
    repeat (3) step();

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_txn_tracker.md
Name: bus_txn_tracker

Overview:
- Synthesizable, parametrised tracker for NUM_CH independent valid/ready request/response channel pairs (ir/dr-style: address handshake, then in-order data handshake).
- Passive tap only; drives nothing on the bus.
- Pairs each data beat with its oldest outstanding address and assigns a per-channel transaction ID and cycle latency.
- Emits one record stream through a round-robin arbiter, with sticky protocol-error flags and per-channel completion counters.
- Used in FPGA builds and simulation in place of non-synthesizable bus logging.

Parameters:
NUM_CH, 3, number of monitored channel pairs (>=1)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
DEPTH, 4, max outstanding addresses per channel (power of 2, >=2)
ID_WIDTH, 8, per-channel transaction ID width
LAT_WIDTH, 16, timestamp/latency width
TIMEOUT, 1000, head-of-queue age that flags timeout (1..2^LAT_WIDTH-1)
CNT_WIDTH, 32, completion counter width
CH_W, 2, channel index width (>=max(1,clog2(NUM_CH)))

Ports:
clk  in  1  clock
rst  in  1  reset
ch_addr_valid  in  NUM_CH  per-channel address valid
ch_addr_ready  in  NUM_CH  per-channel address ready
ch_addr  in  NUM_CH*ADDR_WIDTH  addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_data_valid  in  NUM_CH  per-channel data valid
ch_data_ready  in  NUM_CH  per-channel data ready
ch_data  in  NUM_CH*DATA_WIDTH  data, packed likewise
rec_valid  out  1  record available
rec_ready  in  1  record consumer ready
rec_ch  out  CH_W  record channel index
rec_id  out  ID_WIDTH  record transaction ID
rec_addr  out  ADDR_WIDTH  record address
rec_data  out  DATA_WIDTH  record data
rec_latency  out  LAT_WIDTH  cycles from address handshake to data handshake
err_clr  in  1  synchronous clear of all sticky error flags
err_orphan  out  NUM_CH  data handshake with no outstanding address
err_overflow  out  NUM_CH  address handshake with queue full
err_drop  out  NUM_CH  completed record lost because the slot was occupied
err_timeout  out  NUM_CH  head outstanding age reached TIMEOUT
err_stability  out  NUM_CH  valid dropped or payload changed while stalled
txn_count  out  NUM_CH*CNT_WIDTH  per-channel count of records captured

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset, all outputs are 0, all queues are empty, IDs and the timestamp are 0, and all arbiter pointers point to channel 0.
- Reset mid-transaction discards all outstanding state without emitting records.
- Timestamp: free-running LAT_WIDTH counter, incremented every cycle, wraps.
- Address handshake (valid&&ready), channel i:
  - Push {addr, id_i, timestamp} into channel i's DEPTH-entry FIFO.
  - id_i increments by 1 and wraps at 2^ID_WIDTH.
  - Push is allowed when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs in the same cycle.
  - Otherwise: set err_overflow[i], drop the push, leave id_i unchanged.
- Data handshake, channel i:
  - Matches only entries present at the start of the cycle.
  - If the FIFO is empty: set err_orphan[i] and discard. A same-cycle address is still pushed.
  - Else pop the head and form a record with latency = (timestamp - head.ts) mod 2^LAT_WIDTH. Address and data one cycle apart gives 1.
- Completion slot: one register per channel.
  - A record is captured if the slot is empty, or the slot is being granted and consumed this cycle.
  - On capture, txn_count[i] increments (wraps).
  - Otherwise set err_drop[i] and discard the record; the FIFO pop still occurs.
- Output arbiter:
  - Round-robin over full slots, searching from the channel after the last consumed grant.
  - rec_* is driven combinationally from the granted slot.
  - The grant is stable while rec_valid && !rec_ready.
  - Record is consumed on rec_valid && rec_ready; the slot is freed the same edge.
  - Earliest rec_valid is the cycle after the data handshake.
- Timeout: err_timeout[i] sets when the FIFO is non-empty and (timestamp - head.ts) == TIMEOUT. It is evaluated each cycle.
- Stability: if cycle n-1 had valid && !ready on an address or data channel, cycle n requires valid == 1 and an unchanged payload. Violation sets err_stability[i]; the handshake is still tracked normally.
- Error flags: sticky until err_clr. If err_clr and a set event occur in the same cycle, set wins.

Test Plan:
- Ch0: address 0x100, data 0xDEADBEEF 3 cycles later, rec_ready=1 -> next cycle rec_valid with ch 0, id 0, addr 0x100, data 0xDEADBEEF, latency 3; txn_count[0]=1.
- Ch1: 4 back-to-back addresses 0x0,0x4,0x8,0xC, then 4 data beats -> records with ids 0..3 paired in order. A 5th address with the queue full and no pop -> err_overflow[1]=1 and id does not advance.
- Ch2: data handshake with an empty queue -> err_orphan[2]=1, no record. Assert err_clr -> flag 0 next cycle.
- Ch0 and ch1 complete the same cycle, rec_ready held 0 for 2 cycles -> rec_ch stays 0. Then rec_ready=1 -> ch0 then ch1 emitted. A new ch0 completion while ch0's slot is occupied and not granted -> err_drop[0].
- Address with no data for TIMEOUT cycles -> err_timeout asserts exactly TIMEOUT cycles after the handshake.
- Address stalled (valid=1, ready=0) with addr changing 0x10->0x14 -> err_stability set. Async rst mid-queue -> all outputs 0 immediately; a later data beat -> err_orphan.
